// File: rtl/poly_pkg.sv
// Shared definitions for the load scheduler: FSM state encoding, channel IDs
// and an elaboration-time log2 helper used to size the count ports.
package poly_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic CH_CMD  = 1'b0;
  localparam logic CH_DATA = 1'b1;

  // Ceiling log2; only evaluated on constants.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/poly_load_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the pointer, and the pointer flips each time a grant is taken.
module rr_arb2
  import poly_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_valid,
  output logic       grant_id
);

  logic ptr;

  always_comb begin
    grant_valid = |req;
    grant_id    = CH_CMD;
    if (req == 2'b11) grant_id = ptr;
    else if (req[CH_DATA]) grant_id = CH_DATA;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= CH_CMD;
    else if (advance) ptr <= ~ptr;
  end

endmodule

// File: rtl/poly_load_sched.sv
// Command/data load scheduler: serialises one mem-controller transfer at a
// time between two channels. Define POLY_LOAD_SCHED_WDOG_EN for the WAIT watchdog.
module poly_load_sched
  import poly_pkg::*;
#(
  parameter int BUFFER_SIZE = 1024,
  parameter int TIMEOUT_CYC = 8,
  localparam int AW = log2(BUFFER_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_n_cmd,
  input  logic [AW-1:0] req_n_data,
  input  logic [AW-1:0] cmd_pop,
  input  logic [AW-1:0] data_pop,
  output logic          cmd_start,
  output logic          data_start,
  input  logic          cmd_wr_done,
  input  logic          data_wr_done,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cmd_loaded,
  output logic [AW-1:0] data_loaded,
  output logic          err
);

  state_t        state;
  logic [AW-1:0] rem_cmd;
  logic [AW-1:0] rem_data;
  logic          grant_ch;
  logic          cmd_elig;
  logic          data_elig;
  logic          grant_valid;
  logic          grant_id;
  logic          arb_take;
  logic          got_done;
  logic          timeout;

  assign cmd_elig  = (rem_cmd != '0) && (cmd_pop != '0);
  assign data_elig = (rem_data != '0) && (data_pop != '0);
  assign arb_take  = (state == ST_ARB) && grant_valid;
  assign got_done  = (grant_ch == CH_CMD) ? cmd_wr_done : data_wr_done;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         ({data_elig, cmd_elig}),
    .advance     (arb_take),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef POLY_LOAD_SCHED_WDOG_EN
  localparam int WW = log2(TIMEOUT_CYC) + 1;
  logic [WW-1:0] wait_cnt;

  assign timeout = (state == ST_WAIT) && !got_done && (wait_cnt == WW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else wait_cnt <= '0;
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Outputs are registered alongside the state so each pulse lines up with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_start   <= 1'b0;
      data_start  <= 1'b0;
      rem_cmd     <= '0;
      rem_data    <= '0;
      cmd_loaded  <= '0;
      data_loaded <= '0;
      grant_ch    <= CH_CMD;
    end else begin
      done       <= 1'b0;
      cmd_start  <= 1'b0;
      data_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            rem_cmd     <= req_n_cmd;
            rem_data    <= req_n_data;
            cmd_loaded  <= '0;
            data_loaded <= '0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_ARB;
          end
        end
        ST_ARB: begin
          if ((rem_cmd == '0) && (rem_data == '0)) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (grant_valid) begin
            grant_ch   <= grant_id;
            cmd_start  <= (grant_id == CH_CMD);
            data_start <= (grant_id == CH_DATA);
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (got_done) begin
            // Guarded updates keep rem from wrapping and loaded within the request.
            if (grant_ch == CH_CMD) begin
              if (rem_cmd != '0) begin
                rem_cmd    <= rem_cmd - 1'b1;
                cmd_loaded <= cmd_loaded + 1'b1;
              end
            end else begin
              if (rem_data != '0) begin
                rem_data    <= rem_data - 1'b1;
                data_loaded <= data_loaded + 1'b1;
              end
            end
            state <= ST_ARB;
          end else if (timeout) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_load_sched.sv
// Bench for poly_load_sched: directed vector table, hand-written corner
// sequences and randomized requests checked against a grant-order model.
module tb_poly_load_sched;

  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_n_cmd;
  logic [AW-1:0] req_n_data;
  logic [AW-1:0] cmd_pop;
  logic [AW-1:0] data_pop;
  logic          cmd_start;
  logic          data_start;
  logic          cmd_wr_done;
  logic          data_wr_done;
  logic          busy;
  logic          done;
  logic [AW-1:0] cmd_loaded;
  logic [AW-1:0] data_loaded;
  logic          err;

  poly_load_sched #(.BUFFER_SIZE(1024), .TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_n_cmd    (req_n_cmd),
    .req_n_data   (req_n_data),
    .cmd_pop      (cmd_pop),
    .data_pop     (data_pop),
    .cmd_start    (cmd_start),
    .data_start   (data_start),
    .cmd_wr_done  (cmd_wr_done),
    .data_wr_done (data_wr_done),
    .busy         (busy),
    .done         (done),
    .cmd_loaded   (cmd_loaded),
    .data_loaded  (data_loaded),
    .err          (err)
  );

  typedef struct {
    int         n_cmd;
    int         n_data;
    int         exp_latency;
    int         exp_count;
    logic [7:0] exp_order;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   start_log[$];
  int   exp_log[$];
  int   done_count = 0;
  bit   auto_resp;
  int   resp_delay;
  bit   inject_spur;
  int   resp_cnt = 0;
  bit   resp_ch = 1'b0;
  bit   model_ptr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required end before 2ms");
    $fatal(1, "[TB] global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int log_at(input int idx);
    if (idx < start_log.size()) return start_log[idx];
    return -1;
  endfunction

  // Spec-level reference: remaining counts and a flipping tie-break pointer.
  function automatic void model_request(input int nc, input int nd);
    int rc;
    int rd;
    int g;
    rc = nc;
    rd = nd;
    exp_log.delete();
    while (rc > 0 || rd > 0) begin
      if (rc > 0 && rd > 0) g = int'(model_ptr);
      else g = (rc > 0) ? 0 : 1;
      exp_log.push_back(g);
      if (g == 0) rc--;
      else rd--;
      model_ptr = !model_ptr;
    end
  endfunction

  // Responder/monitor: answers each start after resp_delay cycles and logs pulses.
  initial begin
    cmd_wr_done  = 1'b0;
    data_wr_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cmd_wr_done  = 1'b0;
      data_wr_done = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          if (resp_ch) data_wr_done = 1'b1;
          else cmd_wr_done = 1'b1;
        end else if (inject_spur && !resp_ch) begin
          data_wr_done = 1'b1;
        end
      end
      if (cmd_start || data_start) begin
        check_output("start_exclusive", int'(cmd_start && data_start), 0);
        check_output("one_outstanding", resp_cnt, 0);
        start_log.push_back(data_start ? 1 : 0);
        if (auto_resp) begin
          resp_cnt = resp_delay;
          resp_ch  = data_start;
        end
      end
      if (done) done_count++;
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (6) step();
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input int nc, input int nd, input int budget, output int latency);
    req_n_cmd  = AW'(nc);
    req_n_data = AW'(nd);
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    latency   = -1;
    for (int i = 1; i <= budget; i++) begin
      if (done) begin
        latency = i;
        break;
      end
      step();
    end
    if (latency < 0) check_output("done_wait_expired", latency, 1);
  endtask

  initial begin
    int lat;
    int base;
    int dbase;
    int n;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_n_cmd   = '0;
    req_n_data  = '0;
    cmd_pop     = AW'(5);
    data_pop    = AW'(5);
    auto_resp   = 1'b1;
    resp_delay  = 3;
    inject_spur = 1'b0;

    vecs[0] = '{n_cmd: 0, n_data: 0, exp_latency: 2,  exp_count: 0, exp_order: 8'b0000};
    vecs[1] = '{n_cmd: 2, n_data: 2, exp_latency: 22, exp_count: 4, exp_order: 8'b1010};
    vecs[2] = '{n_cmd: 3, n_data: 0, exp_latency: 17, exp_count: 3, exp_order: 8'b0000};
    vecs[3] = '{n_cmd: 0, n_data: 2, exp_latency: 12, exp_count: 2, exp_order: 8'b0011};
    vecs[4] = '{n_cmd: 1, n_data: 3, exp_latency: 22, exp_count: 4, exp_order: 8'b1110};
    vecs[5] = '{n_cmd: 3, n_data: 1, exp_latency: 22, exp_count: 4, exp_order: 8'b0010};

    repeat (3) step();
    check_output("rst_req_ready", int'(req_ready), 1);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_starts", int'({cmd_start, data_start}), 0);
    check_output("rst_err", int'(err), 0);
    check_output("rst_loaded", int'(cmd_loaded) + int'(data_loaded), 0);
    rst = 1'b0;
    step();

    $display("[TB] directed vector table");
    for (int v = 0; v < 6; v++) begin
      do_reset();
      base  = start_log.size();
      dbase = done_count;
      apply_stimulus(vecs[v].n_cmd, vecs[v].n_data, 300, lat);
      check_output($sformatf("vec%0d_latency", v), lat, vecs[v].exp_latency);
      step();
      check_output($sformatf("vec%0d_done_pulses", v), done_count - dbase, 1);
      check_output($sformatf("vec%0d_done_width", v), int'(done), 0);
      check_output($sformatf("vec%0d_idle_ready", v), int'(req_ready), 1);
      check_output($sformatf("vec%0d_idle_busy", v), int'(busy), 0);
      check_output($sformatf("vec%0d_cmd_loaded", v), int'(cmd_loaded), vecs[v].n_cmd);
      check_output($sformatf("vec%0d_data_loaded", v), int'(data_loaded), vecs[v].n_data);
      check_output($sformatf("vec%0d_start_count", v), start_log.size() - base, vecs[v].exp_count);
      for (int k = 0; k < vecs[v].exp_count; k++)
        check_output($sformatf("vec%0d_start%0d_ch", v, k), log_at(base + k), int'(vecs[v].exp_order[k]));
    end

    $display("[TB] stall with empty data FIFO");
    do_reset();
    data_pop   = '0;
    base       = start_log.size();
    dbase      = done_count;
    req_n_cmd  = AW'(1);
    req_n_data = AW'(3);
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (20) step();
    check_output("stall_starts", start_log.size() - base, 1);
    check_output("stall_first_ch", log_at(base), 0);
    check_output("stall_busy", int'(busy), 1);
    check_output("stall_cmd_loaded", int'(cmd_loaded), 1);
    check_output("stall_no_done", done_count - dbase, 0);
    data_pop = AW'(5);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      step();
    end
    check_output("stall_done_seen", int'(lat > 0), 1);
    check_output("stall_total_starts", start_log.size() - base, 4);
    check_output("stall_data_starts", log_at(base + 1) + log_at(base + 2) + log_at(base + 3), 3);
    check_output("stall_data_loaded", int'(data_loaded), 3);
    step();

    $display("[TB] reset during WAIT of second transfer");
    do_reset();
    base  = start_log.size();
    dbase = done_count;
    req_n_cmd  = AW'(2);
    req_n_data = AW'(2);
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    n = 0;
    while (start_log.size() < base + 2 && n < 50) begin
      step();
      n++;
    end
    check_output("rstwait_reached", int'(start_log.size() >= base + 2), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("rstwait_ready", int'(req_ready), 1);
    check_output("rstwait_busy", int'(busy), 0);
    check_output("rstwait_loaded", int'(cmd_loaded) + int'(data_loaded), 0);
    repeat (6) step();
    check_output("rstwait_no_done", done_count - dbase, 0);
    check_output("rstwait_no_more_starts", start_log.size() - base, 2);

    $display("[TB] spurious data_wr_done during cmd WAIT");
    do_reset();
    inject_spur = 1'b1;
    base = start_log.size();
    apply_stimulus(1, 0, 100, lat);
    inject_spur = 1'b0;
    check_output("spur_latency", lat, 7);
    check_output("spur_cmd_loaded", int'(cmd_loaded), 1);
    check_output("spur_data_loaded", int'(data_loaded), 0);
    check_output("spur_starts", start_log.size() - base, 1);
    step();

`ifdef POLY_LOAD_SCHED_WDOG_EN
    $display("[TB] watchdog timeout");
    do_reset();
    auto_resp = 1'b0;
    apply_stimulus(1, 0, 100, lat);
    check_output("wdog_latency", lat, 11);
    check_output("wdog_err_at_done", int'(err), 1);
    check_output("wdog_cmd_loaded", int'(cmd_loaded), 0);
    repeat (5) step();
    check_output("wdog_err_sticky", int'(err), 1);
    auto_resp = 1'b1;
    do_reset();
    check_output("wdog_err_cleared", int'(err), 0);
`else
    $display("[TB] watchdog absent: withheld wr_done keeps WAIT");
    do_reset();
    auto_resp = 1'b0;
    req_n_cmd  = AW'(1);
    req_n_data = AW'(0);
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    dbase = done_count;
    repeat (30) step();
    check_output("nowdog_busy", int'(busy), 1);
    check_output("nowdog_no_done", done_count - dbase, 0);
    check_output("nowdog_err", int'(err), 0);
    auto_resp = 1'b1;
`endif

    $display("[TB] randomized requests against reference model");
    do_reset();
    model_ptr = 1'b0;
    for (int r = 0; r < 15; r++) begin
      int nc;
      int nd;
      nc         = int'($urandom_range(0, 4));
      nd         = int'($urandom_range(0, 4));
      cmd_pop    = AW'($urandom_range(1, 1023));
      data_pop   = AW'($urandom_range(1, 1023));
      resp_delay = int'($urandom_range(1, 5));
      base  = start_log.size();
      dbase = done_count;
      apply_stimulus(nc, nd, 300, lat);
      model_request(nc, nd);
      step();
      check_output($sformatf("rnd%0d_done_once", r), done_count - dbase, 1);
      check_output($sformatf("rnd%0d_cmd_loaded", r), int'(cmd_loaded), nc);
      check_output($sformatf("rnd%0d_data_loaded", r), int'(data_loaded), nd);
      check_output($sformatf("rnd%0d_start_count", r), start_log.size() - base, exp_log.size());
      for (int k = 0; k < exp_log.size(); k++)
        check_output($sformatf("rnd%0d_start%0d_ch", r, k), log_at(base + k), exp_log[k]);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
